// File: rtl/lockstep_pkg.sv
// -----------------------------------------------------------------------------
// lockstep_pkg
// Shared types and constants for the lockstep configuration initiator.
//   lk_init_state_t  : initiator FSM state encoding
//   LOCKSTEP_ADDRESS : byte address of the lockstep control register
//   lk_cmd_t         : one front-end command (address, direction, data, strobes)
// -----------------------------------------------------------------------------
package lockstep_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        RESP     = 2'd3
    } lk_init_state_t;

    localparam logic [31:0] LOCKSTEP_ADDRESS = 32'h1020_2800;

    typedef struct packed {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  be;
    } lk_cmd_t;

endpackage

// File: rtl/lockstep_cfg_initiator_if.sv
// -----------------------------------------------------------------------------
// lockstep_cfg_initiator_if
// Peripheral req/gnt/r_valid bus between the initiator and the lockstep
// responder.
//   req/addr/wen/wdata/be/id : request channel, driven by the master
//   gnt                      : grant, driven by the slave
//   r_valid/r_opc/r_id/r_rdata : response channel, driven by the slave
// wen is active-low: 0 = write, 1 = read.
// -----------------------------------------------------------------------------
interface lockstep_cfg_initiator_if #(
    parameter int unsigned ID_WIDTH = 5
);
    logic                req;
    logic [31:0]         addr;
    logic                wen;
    logic [31:0]         wdata;
    logic [3:0]          be;
    logic [ID_WIDTH-1:0] id;
    logic                gnt;
    logic                r_valid;
    logic                r_opc;
    logic [ID_WIDTH-1:0] r_id;
    logic [31:0]         r_rdata;

    modport master (
        output req, addr, wen, wdata, be, id,
        input  gnt, r_valid, r_opc, r_id, r_rdata
    );

    modport slave (
        input  req, addr, wen, wdata, be, id,
        output gnt, r_valid, r_opc, r_id, r_rdata
    );
endinterface

// File: rtl/lockstep_timeout_cnt.sv
// -----------------------------------------------------------------------------
// lockstep_timeout_cnt
// Response-timeout counter. Cleared by clear_i, counts while enable_i, and
// saturates at TO_CYCLES.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clear_i       : restart the count from zero (has priority over enable_i)
//   enable_i      : count this cycle
//   expired_o     : count has reached TO_CYCLES
// -----------------------------------------------------------------------------
module lockstep_timeout_cnt #(
    parameter int unsigned TO_WIDTH  = 8,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);
    localparam logic [TO_WIDTH-1:0] TO_LIMIT = TO_WIDTH'(TO_CYCLES);

    logic [TO_WIDTH-1:0] cnt_r;

    // Counter register: clear, then count up to the limit and hold there.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_r <= {TO_WIDTH{1'b0}};
        end else if (clear_i) begin
            cnt_r <= {TO_WIDTH{1'b0}};
        end else if (enable_i && (cnt_r != TO_LIMIT)) begin
            cnt_r <= cnt_r + {{(TO_WIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired_o = (cnt_r == TO_LIMIT);

endmodule

// File: rtl/lockstep_cfg_initiator.sv
// -----------------------------------------------------------------------------
// lockstep_cfg_initiator
// Converts one valid/ready command into exactly one req/gnt/r_valid bus
// transaction and returns the result on a valid/ready response port. Only one
// transaction is outstanding at a time; every output is a register.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   cmd_valid_i / cmd_ready_o : command handshake
//   cmd_addr_i/we_i/wdata_i/be_i : command payload (we=1 write)
//   rsp_valid_o / rsp_ready_i : response handshake
//   rsp_rdata_o, rsp_err_o    : read data (0 on write/error), error flag
//   busy_o                    : a transaction is in progress
//   bus                       : master side of the peripheral bus
// -----------------------------------------------------------------------------
module lockstep_cfg_initiator
    import lockstep_pkg::*;
#(
    parameter int unsigned ID_WIDTH  = 5,
    parameter int unsigned TO_WIDTH  = 8,
    parameter int unsigned TO_CYCLES = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_addr_i,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_wdata_i,
    input  logic [3:0]  cmd_be_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    lockstep_cfg_initiator_if.master bus
);
    lk_init_state_t state_r, state_nxt_s;
    lk_cmd_t        cmd_in_s;

    logic                cmd_ready_r, cmd_ready_nxt_s;
    logic                req_r, req_nxt_s;
    logic [31:0]         addr_r, addr_nxt_s;
    logic                wen_r, wen_nxt_s;
    logic [31:0]         wdata_r, wdata_nxt_s;
    logic [3:0]          be_r, be_nxt_s;
    logic [ID_WIDTH-1:0] tag_r, tag_nxt_s;
    logic                rsp_valid_r, rsp_valid_nxt_s;
    logic [31:0]         rsp_rdata_r, rsp_rdata_nxt_s;
    logic                rsp_err_r, rsp_err_nxt_s;
    logic                busy_r, busy_nxt_s;
    logic                to_clear_s, to_enable_s, to_expired_s, match_s;

    assign cmd_in_s = '{addr: cmd_addr_i, we: cmd_we_i, wdata: cmd_wdata_i, be: cmd_be_i};

    lockstep_timeout_cnt #(
        .TO_WIDTH  (TO_WIDTH),
        .TO_CYCLES (TO_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .clear_i   (to_clear_s),
        .enable_i  (to_enable_s),
        .expired_o (to_expired_s)
    );

    // A response only counts if it carries the tag of the outstanding request.
    assign match_s     = bus.r_valid && (bus.r_id == tag_r);
    assign to_clear_s  = (state_r == REQ) && bus.gnt;
    assign to_enable_s = (state_r == WAIT_RSP);

    // Next-state and next-output decode; every register holds by default.
    always_comb begin
        state_nxt_s     = state_r;
        req_nxt_s       = req_r;
        addr_nxt_s      = addr_r;
        wen_nxt_s       = wen_r;
        wdata_nxt_s     = wdata_r;
        be_nxt_s        = be_r;
        tag_nxt_s       = tag_r;
        rsp_valid_nxt_s = rsp_valid_r;
        rsp_rdata_nxt_s = rsp_rdata_r;
        rsp_err_nxt_s   = rsp_err_r;
        case (state_r)
            IDLE: begin
                if (cmd_ready_r && cmd_valid_i) begin
                    state_nxt_s = REQ;
                    req_nxt_s   = 1'b1;
                    addr_nxt_s  = cmd_in_s.addr;
                    wen_nxt_s   = ~cmd_in_s.we;
                    wdata_nxt_s = cmd_in_s.wdata;
                    be_nxt_s    = cmd_in_s.be;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            REQ: begin
                // No timeout here: the arbiter may stall indefinitely.
                if (bus.gnt) begin
                    state_nxt_s = WAIT_RSP;
                    req_nxt_s   = 1'b0;
                end else begin
                    state_nxt_s = REQ;
                end
            end
            WAIT_RSP: begin
                // A matching response beats a simultaneous timeout.
                if (match_s) begin
                    state_nxt_s     = RESP;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = bus.r_opc;
                    rsp_rdata_nxt_s = (wen_r && !bus.r_opc) ? bus.r_rdata : 32'h0000_0000;
                end else if (to_expired_s) begin
                    state_nxt_s     = RESP;
                    rsp_valid_nxt_s = 1'b1;
                    rsp_err_nxt_s   = 1'b1;
                    rsp_rdata_nxt_s = 32'h0000_0000;
                end else begin
                    state_nxt_s = WAIT_RSP;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    state_nxt_s     = IDLE;
                    rsp_valid_nxt_s = 1'b0;
                    tag_nxt_s       = tag_r + {{(ID_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    state_nxt_s = RESP;
                end
            end
            default: begin
                state_nxt_s     = IDLE;
                req_nxt_s       = 1'b0;
                rsp_valid_nxt_s = 1'b0;
            end
        endcase
        cmd_ready_nxt_s = (state_nxt_s == IDLE);
        busy_nxt_s      = (state_nxt_s != IDLE);
    end

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Output and tag registers; wen resets to read so an idle bus is harmless.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_ready_r <= 1'b0;
            req_r       <= 1'b0;
            addr_r      <= 32'h0000_0000;
            wen_r       <= 1'b1;
            wdata_r     <= 32'h0000_0000;
            be_r        <= 4'h0;
            tag_r       <= {ID_WIDTH{1'b0}};
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 32'h0000_0000;
            rsp_err_r   <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            cmd_ready_r <= cmd_ready_nxt_s;
            req_r       <= req_nxt_s;
            addr_r      <= addr_nxt_s;
            wen_r       <= wen_nxt_s;
            wdata_r     <= wdata_nxt_s;
            be_r        <= be_nxt_s;
            tag_r       <= tag_nxt_s;
            rsp_valid_r <= rsp_valid_nxt_s;
            rsp_rdata_r <= rsp_rdata_nxt_s;
            rsp_err_r   <= rsp_err_nxt_s;
            busy_r      <= busy_nxt_s;
        end
    end

    assign cmd_ready_o = cmd_ready_r;
    assign rsp_valid_o = rsp_valid_r;
    assign rsp_rdata_o = rsp_rdata_r;
    assign rsp_err_o   = rsp_err_r;
    assign busy_o      = busy_r;
    assign bus.req     = req_r;
    assign bus.addr    = addr_r;
    assign bus.wen     = wen_r;
    assign bus.wdata   = wdata_r;
    assign bus.be      = be_r;
    assign bus.id      = tag_r;

endmodule

// File: tb/tb_lockstep_cfg_initiator.sv
// -----------------------------------------------------------------------------
// tb_lockstep_cfg_initiator
// Self-checking bench: a behavioural lockstep responder on the bus side, a
// command driver, and a scoreboard of expected responses.
// -----------------------------------------------------------------------------
module tb_lockstep_cfg_initiator;
    import lockstep_pkg::*;

    localparam int TO_CYC = 255;
    localparam int MODE_NORMAL = 0;
    localparam int MODE_BADID  = 1;
    localparam int MODE_SILENT = 2;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [31:0] cmd_addr_i = 32'h0;
    logic        cmd_we_i = 1'b0;
    logic [31:0] cmd_wdata_i = 32'h0;
    logic [3:0]  cmd_be_i = 4'h0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        busy_o;

    lockstep_cfg_initiator_if #(.ID_WIDTH(5)) bus ();

    lockstep_cfg_initiator #(.ID_WIDTH(5), .TO_WIDTH(8), .TO_CYCLES(TO_CYC)) dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmd_valid_i (cmd_valid_i),
        .cmd_ready_o (cmd_ready_o),
        .cmd_addr_i  (cmd_addr_i),
        .cmd_we_i    (cmd_we_i),
        .cmd_wdata_i (cmd_wdata_i),
        .cmd_be_i    (cmd_be_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_rdata_o (rsp_rdata_o),
        .rsp_err_o   (rsp_err_o),
        .busy_o      (busy_o),
        .bus         (bus)
    );

    always #5 clk_i = ~clk_i;

    int n_checks = 0;
    int n_errors = 0;

    exp_t        sb_q[$];
    bit   [31:0] model_mem[bit [31:0]];
    bit   [31:0] resp_mem[bit [31:0]];
    logic [4:0]  exp_id = 5'd0;

    // responder state
    int          resp_mode = MODE_NORMAL;
    int          gnt_wait = 0;
    bit          err_inj = 1'b0;
    int          sched_cnt = 0;
    bit          bad_pending = 1'b0;
    logic [4:0]  lat_id;
    logic [31:0] lat_rdata;
    logic        lat_opc;

    // monitors
    int          req_cycles = 0;
    int          stab_err = 0;
    int          rsp_pulses = 0;
    logic        rsp_valid_q = 1'b0;
    logic [31:0] snap_addr, snap_wdata;
    logic        snap_wen;
    logic [4:0]  snap_id;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // One clock: sample at the falling edge, then drive the responder.
    task automatic tick();
        @(negedge clk_i);
        if (rsp_valid_o && !rsp_valid_q) rsp_pulses++;
        rsp_valid_q = rsp_valid_o;
        if (bus.req) begin
            req_cycles++;
            if (bus.addr !== snap_addr || bus.wdata !== snap_wdata ||
                bus.wen !== snap_wen || bus.id !== snap_id) stab_err++;
        end
        bus.r_valid = 1'b0;
        if (sched_cnt > 0) begin
            sched_cnt--;
            if (sched_cnt == 0) begin
                bus.r_valid = 1'b1;
                bus.r_rdata = lat_rdata;
                bus.r_opc   = lat_opc;
                if (bad_pending) begin
                    bus.r_id    = lat_id ^ 5'd1;
                    bad_pending = 1'b0;
                    sched_cnt   = 2;
                end else begin
                    bus.r_id = lat_id;
                end
            end
        end
        if (bus.req) begin
            if (gnt_wait > 0) begin
                bus.gnt = 1'b0;
                gnt_wait--;
            end else begin
                bus.gnt   = 1'b1;
                lat_id    = bus.id;
                lat_opc   = err_inj;
                if (!bus.wen) resp_mem[bus.addr] = bus.wdata;
                lat_rdata = bus.wen ? (resp_mem.exists(bus.addr) ? resp_mem[bus.addr] : 32'h0)
                                    : 32'hDEAD_BEEF;
                sched_cnt   = (resp_mode == MODE_SILENT) ? 0 : 1;
                bad_pending = (resp_mode == MODE_BADID);
            end
        end else begin
            bus.gnt = 1'b1;
        end
    endtask

    task automatic run_txn(input string tag, input logic [31:0] addr, input logic we,
                           input logic [31:0] wdata, input int mode, input int gwait,
                           input bit einj, input int hold, input int exp_lat);
        int   w;
        int   lat;
        int   pulses0;
        int   hold_bad;
        exp_t e;
        logic [31:0] h_rdata;
        logic        h_err;
        w = 0;
        while (!cmd_ready_o && w < 20) begin tick(); w++; end
        chk({tag, "_ready"}, 64'(cmd_ready_o), 64'd1);
        e.err   = einj || (mode == MODE_SILENT);
        e.rdata = (we || e.err) ? 32'h0 : (model_mem.exists(addr) ? model_mem[addr] : 32'h0);
        if (we && !e.err) model_mem[addr] = wdata;
        sb_q.push_back(e);
        resp_mode = mode; gnt_wait = gwait; err_inj = einj;
        snap_addr = addr; snap_wdata = wdata; snap_wen = ~we; snap_id = exp_id;
        req_cycles = 0; stab_err = 0; pulses0 = rsp_pulses;
        cmd_addr_i = addr; cmd_we_i = we; cmd_wdata_i = wdata; cmd_be_i = 4'hF;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        lat = 1;
        while (!rsp_valid_o && lat < 400) begin tick(); lat++; end
        chk({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_req_cycles"}, 64'(req_cycles), 64'(gwait + 1));
        chk({tag, "_req_stable"}, 64'(stab_err), 64'd0);
        h_rdata = rsp_rdata_o; h_err = rsp_err_o; hold_bad = 0;
        for (int i = 0; i < hold; i++) begin
            tick();
            if (!rsp_valid_o || rsp_rdata_o !== h_rdata || rsp_err_o !== h_err) hold_bad++;
        end
        if (hold > 0) chk({tag, "_hold"}, 64'(hold_bad), 64'd0);
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            chk({tag, "_rdata"}, 64'(rsp_rdata_o), 64'(e.rdata));
            chk({tag, "_err"}, 64'(rsp_err_o), 64'(e.err));
        end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        chk({tag, "_rsp_drop"}, 64'(rsp_valid_o), 64'd0);
        chk({tag, "_b2b_ready"}, 64'(cmd_ready_o), 64'd1);
        chk({tag, "_pulses"}, 64'(rsp_pulses - pulses0), 64'd1);
        exp_id = exp_id + 5'd1;
    endtask

    initial begin
        bus.gnt = 1'b1; bus.r_valid = 1'b0; bus.r_opc = 1'b0;
        bus.r_id = 5'd0; bus.r_rdata = 32'h0;
        rst_ni = 1'b0;
        tick(); tick();
        chk("rst_req", 64'(bus.req), 64'd0);
        chk("rst_wen", 64'(bus.wen), 64'd1);
        chk("rst_id", 64'(bus.id), 64'd0);
        chk("rst_busy", 64'(busy_o), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("rst_cmd_ready", 64'(cmd_ready_o), 64'd0);
        chk("rst_addr", 64'(bus.addr), 64'd0);
        rst_ni = 1'b1;
        tick();

        run_txn("wr",     LOCKSTEP_ADDRESS,          1'b1, 32'hA5A5_0001, MODE_NORMAL, 0, 1'b0, 0, 3);
        run_txn("rd",     LOCKSTEP_ADDRESS,          1'b0, 32'h0,         MODE_NORMAL, 0, 1'b0, 0, 3);
        run_txn("gntw",   LOCKSTEP_ADDRESS + 32'd4,  1'b1, 32'h1234_5678, MODE_NORMAL, 3, 1'b0, 0, 6);
        run_txn("badid",  LOCKSTEP_ADDRESS,          1'b0, 32'h0,         MODE_BADID,  0, 1'b0, 0, 5);
        run_txn("opcerr", LOCKSTEP_ADDRESS + 32'd4,  1'b0, 32'h0,         MODE_NORMAL, 0, 1'b1, 0, 3);
        run_txn("tmo",    LOCKSTEP_ADDRESS,          1'b0, 32'h0,         MODE_SILENT, 0, 1'b0, 0, TO_CYC + 3);
        run_txn("hold",   LOCKSTEP_ADDRESS + 32'd4,  1'b0, 32'h0,         MODE_NORMAL, 0, 1'b0, 5, 3);

        // Reset while waiting for a response that never comes.
        resp_mode = MODE_SILENT; gnt_wait = 0; err_inj = 1'b0;
        snap_addr = LOCKSTEP_ADDRESS; snap_wdata = 32'h0; snap_wen = 1'b1; snap_id = exp_id;
        cmd_addr_i = LOCKSTEP_ADDRESS; cmd_we_i = 1'b0; cmd_be_i = 4'hF;
        cmd_valid_i = 1'b1;
        tick();
        cmd_valid_i = 1'b0;
        tick(); tick(); tick();
        chk("mid_busy", 64'(busy_o), 64'd1);
        chk("mid_id", 64'(bus.id), 64'(exp_id));
        rst_ni = 1'b0;
        #1;
        chk("arst_req", 64'(bus.req), 64'd0);
        chk("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
        chk("arst_busy", 64'(busy_o), 64'd0);
        chk("arst_id", 64'(bus.id), 64'd0);
        chk("arst_wen", 64'(bus.wen), 64'd1);
        chk("arst_rdata", 64'(rsp_rdata_o), 64'd0);
        sb_q.delete();
        sched_cnt = 0; bad_pending = 1'b0;
        exp_id = 5'd0;
        tick();
        rst_ni = 1'b1;
        tick();
        chk("post_rst_ready", 64'(cmd_ready_o), 64'd1);
        run_txn("post_rd", LOCKSTEP_ADDRESS, 1'b0, 32'h0, MODE_NORMAL, 0, 1'b0, 0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
